gearbox_tx_sched: RTL and testbench
===================================

Name: gearbox_tx_sched

Overview:
Sequencer and feeder for the 10GBASE-R TX 66b->32b gearbox.
- Accepts 66-bit encoded blocks (2-bit sync header + 64-bit payload) from the PCS encoder over a valid/ready handshake, buffered in a small FIFO.
- Drives the gearbox din/ctrl/din_en/even inputs on the mandatory 33-cycle schedule: 32 enabled half-block words, then 1 pause cycle, which gives 16 blocks per period.
- Inserts idle blocks on encoder underflow so the serial stream never stalls.

Parameters:
- FIFO_DEPTH, 4, block FIFO entries; power of 2, minimum 2.
- IDLE_HDR, 2'b10, sync header of the inserted idle block.
- IDLE_PAYLOAD, 64'h0000_0000_0000_001E, payload of the inserted idle block (type 0x1E, all /I/).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, input, 1, TX PCS clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scheduler run enable.
- in_valid, input, 1, encoder block valid.
- in_hdr, input, 2, sync header.
- in_payload, input, 64, block payload; bit 0 is transmitted first.
- in_ready, output, 1, FIFO can accept a block.
- gbx_din, output, 32, to gearbox din.
- gbx_ctrl, output, 2, to gearbox ctrl.
- gbx_din_en, output, 1, to gearbox din_en.
- gbx_even, output, 1, to gearbox even; high on the header half-word.
- period_start, output, 1, 1-cycle pulse coincident with phase 0.
- underflow_cnt, output, CNT_W, count of idle blocks inserted.
- block_cnt, output, CNT_W, count of encoder blocks transmitted.

Behaviour:
- All outputs are registered.
- Reset values:
  - gbx_din=0, gbx_ctrl=0, gbx_din_en=0, gbx_even=0, period_start=0.
  - in_ready=0 in the reset cycle, 1 from the first cycle after rst deasserts.
  - Counters=0, FIFO empty, phase=PAUSE(32).
- Phase counter runs 0..32.
  - Phases 0..31: gbx_din_en=1.
  - Phase 32 (pause): gbx_din_en=0, gbx_din=0, gbx_ctrl=0, gbx_even=0.
  - Phase advances 32->0 and wraps after 32.
- States:
  - IDLE: en=0. Phase held at 32, din_en=0, FIFO still accepts blocks.
  - RUN: entered the cycle after en is sampled high; the first output cycle is phase 0.
  - When en is sampled low, the current period completes through phase 32, then the block returns to IDLE.
  - A period is never truncated, because the gearbox counter must see its pause.
- Even phase (p=0,2,...,30):
  - Pop the FIFO head into the hold register.
  - gbx_din = payload[31:0], gbx_ctrl = hdr, gbx_even=1.
  - If the FIFO is empty: use IDLE_HDR/IDLE_PAYLOAD and increment underflow_cnt.
  - Otherwise increment block_cnt.
- Odd phase: gbx_din = hold payload[63:32], gbx_ctrl = hold hdr, gbx_even=0.
- period_start=1 exactly in the cycles where phase=0.
- Handshake:
  - Push when in_valid && in_ready.
  - in_ready = (occupancy < FIFO_DEPTH), registered, with pop accounted for in the same cycle.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - A block pushed in cycle t is eligible for a pop at the earliest in cycle t+1.
  - Encoder data is never dropped or reordered.
- Counters saturate at all-ones; they do not wrap.
- rst asserted mid-period:
  - Next cycle shows reset values and the FIFO is flushed.
  - The gearbox sees din_en=0 and realigns.
  - After release, operation restarts at phase 0 only when en is high.

Optional Feature:
- Macro: GBX_SCHED_STATS_EN.
- Defined: underflow_cnt and block_cnt are implemented as described.
- Undefined: both outputs are tied to 0 and no counter registers are synthesized. Idle insertion still occurs.

Test Plan:
- FIFO kept non-empty, en=1 for 3 periods -> gbx_din_en low exactly at cycles 32, 65, 98 after the first phase 0; period_start at 0, 33, 66; gbx_even alternates 1,0 across phases 0..31.
- Push blocks {hdr=01, payload=64'h1111_2222_3333_4444} then {hdr=10, payload=64'hAAAA_BBBB_CCCC_DDDD} -> gbx_din sequence 3333_4444, 1111_2222, CCCC_DDDD, AAAA_BBBB with gbx_ctrl 01,01,10,10; block_cnt=2.
- en=1 with in_valid=0 -> every even phase drives ctrl=10, din=0000_001E, next odd din=0; underflow_cnt=16 after one period.
- Hold in_valid=1 and stall pops (en=0) -> in_ready drops after 4 accepted blocks; after en=1, in_ready returns high the cycle after the first pop; no block is lost.
- Drop en at phase 10 -> phases 11..32 still issued, then din_en stays 0; with rst at phase 7 instead -> next cycle all outputs 0, FIFO empty.
- Connect to the gearbox, stream 32 sequential blocks -> the 66 gearbox output words concatenated equal the 32 blocks' {payload, hdr} concatenated LSB-first.

Source files
------------

// File: rtl/gearbox_tx_sched.sv
// TX scheduler for the 66b->32b gearbox: buffers encoder blocks and issues the 33-cycle
// half-word schedule with idle insertion. Define GBX_SCHED_STATS_EN to build the statistics counters.
module gearbox_tx_sched #(
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [1:0]  IDLE_HDR     = 2'b10,
   parameter logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic [1:0]       in_hdr,
   input  logic [63:0]      in_payload,
   output logic             in_ready,
   output logic [31:0]      gbx_din,
   output logic [1:0]       gbx_ctrl,
   output logic             gbx_din_en,
   output logic             gbx_even,
   output logic             period_start,
   output logic [CNT_W-1:0] underflow_cnt,
   output logic [CNT_W-1:0] block_cnt
);

   localparam int          AW    = $clog2(FIFO_DEPTH);
   localparam int          OW    = AW + 1;
   localparam logic [5:0]  PAUSE = 6'd32;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [5:0]      phase_q, phase_d;
   logic [65:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [OW-1:0]   count_q, count_d;
   logic [65:0]     hold_blk, sel_blk;
   logic            push, pop, issue_even;

   // Next-state and phase sequencing; a period always runs through its pause before stopping
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      case (state_q)
         IDLE: begin
            phase_d = PAUSE;
            if (en) begin
               state_d = RUN;
               phase_d = 6'd0;
            end
         end
         RUN: begin
            if (phase_q == PAUSE) begin
               if (en) phase_d = 6'd0;
               else    state_d = IDLE;
            end else begin
               phase_d = phase_q + 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = PAUSE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= PAUSE;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Pops only see blocks pushed on earlier edges, since count_q excludes this edge's push
   assign issue_even = (phase_d != PAUSE) && !phase_d[0];
   assign push       = in_valid && in_ready;
   assign pop        = issue_even && (count_q != '0);
   assign count_d    = count_q + OW'(push) - OW'(pop);
   assign sel_blk    = pop ? mem[rd_ptr] : {IDLE_HDR, IDLE_PAYLOAD};

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_hdr, in_payload};
      if (issue_even) hold_blk <= sel_blk;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count_q  <= count_d;
         in_ready <= (count_d < OW'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gbx_din      <= '0;
         gbx_ctrl     <= '0;
         gbx_din_en   <= 1'b0;
         gbx_even     <= 1'b0;
         period_start <= 1'b0;
      end else begin
         gbx_din_en   <= (phase_d != PAUSE);
         period_start <= (phase_d == 6'd0);
         if (phase_d == PAUSE) begin
            gbx_din  <= '0;
            gbx_ctrl <= '0;
            gbx_even <= 1'b0;
         end else if (issue_even) begin
            gbx_din  <= sel_blk[31:0];
            gbx_ctrl <= sel_blk[65:64];
            gbx_even <= 1'b1;
         end else begin
            gbx_din  <= hold_blk[63:32];
            gbx_ctrl <= hold_blk[65:64];
            gbx_even <= 1'b0;
         end
      end
   end

`ifdef GBX_SCHED_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] und_q, blk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         und_q <= '0;
         blk_q <= '0;
      end else if (issue_even) begin
         if (pop) blk_q <= sat_inc(blk_q);
         else     und_q <= sat_inc(und_q);
      end
   end

   assign underflow_cnt = und_q;
   assign block_cnt     = blk_q;
`else
   assign underflow_cnt = '0;
   assign block_cnt     = '0;
`endif

endmodule

// File: tb/tb_gearbox_tx_sched.sv
// Randomized scoreboard bench for gearbox_tx_sched: accepted blocks queue up as expected
// responses, and a negedge monitor checks every output cycle against the schedule rules.
module tb_gearbox_tx_sched;

   localparam int          CNT_W    = 16;
   localparam logic [1:0]  IDLE_H   = 2'b10;
   localparam logic [63:0] IDLE_P   = 64'h0000_0000_0000_001E;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             in_valid = 1'b0;
   logic [1:0]       in_hdr = '0;
   logic [63:0]      in_payload = '0;
   logic             in_ready;
   logic [31:0]      gbx_din;
   logic [1:0]       gbx_ctrl;
   logic             gbx_din_en, gbx_even, period_start;
   logic [CNT_W-1:0] underflow_cnt, block_cnt;

   gearbox_tx_sched #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_hdr(in_hdr),
      .in_payload(in_payload), .in_ready(in_ready), .gbx_din(gbx_din),
      .gbx_ctrl(gbx_ctrl), .gbx_din_en(gbx_din_en), .gbx_even(gbx_even),
      .period_start(period_start), .underflow_cnt(underflow_cnt), .block_cnt(block_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  hdr;
      logic [63:0] pl;
   } blk_t;

   blk_t        exp_q[$];
   int unsigned cyc = 0;
   int          mphase = 32;
   bit          armed = 0;
   bit          rst_seen = 0;
   int          mblk = 0, mund = 0;
   logic [65:0] held = '0;
   int          n_chk = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference side: record accepted blocks and advance the expected phase on each edge
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         armed    = 1;
         rst_seen = 1;
         exp_q.delete();
         mphase   = 32;
         mblk     = 0;
         mund     = 0;
      end else begin
         rst_seen = 0;
         if (in_valid && in_ready) begin
            blk_t b;
            b.cyc = cyc; b.hdr = in_hdr; b.pl = in_payload;
            exp_q.push_back(b);
         end
         if (mphase == 32) mphase = en ? 0 : 32;
         else              mphase = mphase + 1;
      end
   end

   // Monitor: compare the outputs presented by the edge just past
   always @(negedge clk) begin
      if (armed) begin
         logic [65:0] blk;
         logic [31:0] e_din;
         logic [1:0]  e_ctrl;
         int          e_rdy, e_und, e_blk;
         e_din  = '0;
         e_ctrl = '0;
         if (mphase < 32 && (mphase % 2) == 0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               blk_t b;
               b   = exp_q.pop_front();
               blk = {b.hdr, b.pl};
               if (mblk < 65535) mblk++;
            end else begin
               blk = {IDLE_H, IDLE_P};
               if (mund < 65535) mund++;
            end
            held   = blk;
            e_din  = blk[31:0];
            e_ctrl = blk[65:64];
         end else if (mphase < 32) begin
            e_din  = held[63:32];
            e_ctrl = held[65:64];
         end
         e_rdy = rst_seen ? 0 : (exp_q.size() < 4 ? 1 : 0);
`ifdef GBX_SCHED_STATS_EN
         e_und = mund;
         e_blk = mblk;
`else
         e_und = 0;
         e_blk = 0;
`endif
         check("din_en", 64'(gbx_din_en), 64'(mphase != 32));
         check("period_start", 64'(period_start), 64'(mphase == 0));
         check("even", 64'(gbx_even), 64'(mphase < 32 && (mphase % 2) == 0));
         check("din", 64'(gbx_din), 64'(e_din));
         check("ctrl", 64'(gbx_ctrl), 64'(e_ctrl));
         check("in_ready", 64'(in_ready), 64'(e_rdy));
         check("underflow_cnt", 64'(underflow_cnt), 64'(e_und));
         check("block_cnt", 64'(block_cnt), 64'(e_blk));
      end
   end

   task automatic drive_rand(input int cycles, input int en_pct, input int vld_pct);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         en         = ($urandom_range(99) < en_pct);
         in_valid   = ($urandom_range(99) < vld_pct);
         in_hdr     = 2'($urandom_range(3));
         in_payload = {$urandom, $urandom};
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fill the FIFO with the scheduler stopped; the first two blocks are known patterns
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         if (i == 0)      begin in_hdr = 2'b01; in_payload = 64'h1111_2222_3333_4444; end
         else if (i == 1) begin in_hdr = 2'b10; in_payload = 64'hAAAA_BBBB_CCCC_DDDD; end
         else             begin in_hdr = 2'($urandom_range(3)); in_payload = {$urandom, $urandom}; end
      end

      drive_rand(110, 100, 50);
      drive_rand(40, 100, 0);
      drive_rand(300, 92, 60);

      // Reset in the middle of a period
      en = 1'b1;
      begin
         int waited = 0;
         @(negedge clk);
         while (mphase != 7 && waited < 100) begin
            @(negedge clk);
            waited++;
         end
         if (mphase != 7) begin
            n_chk++;
            $display("FAIL phase7_wait: phase %0d expected 7 within 100 cycles", mphase);
         end
      end
      rst      = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      drive_rand(120, 95, 70);

      @(negedge clk);
      en       = 1'b0;
      in_valid = 1'b0;
      repeat (45) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
